// File: rtl/difference_unit.sv
// ============================================================================
// difference_unit
// ----------------------------------------------------------------------------
// Purpose:
//   Undoes an accumulation stage. A stream of running-sum complex words
//   {real, imag} is turned back into per-sample values:
//       out[n] = in[n] - in[n-1]
//   The history is zeroed at every frame start. Each component wraps modulo
//   2^DATA_W, and there is no carry between the real and imag halves.
//   The block has a single registered output stage with valid/ready
//   handshakes on both sides and tracks frame length.
//
// Parameters:
//   DATA_W     width of each component (word is 2*DATA_W bits)
//   FRAME_LEN  samples per frame (>= 2)
//
// Ports:
//   clk        rising-edge clock
//   nrst       asynchronous active-low reset
//   clr        synchronous clear of history, frame count and output word
//   in_valid   input word valid
//   in_ready   block can accept an input word this cycle
//   in_data    {real, imag} accumulated value
//   in_last    marks the last word of a frame
//   out_valid  output word valid
//   out_ready  downstream accepts the output word
//   out_data   {real, imag} differenced sample
//   out_last   output word is the last of its frame
//   frame_err  one-cycle pulse: in_last disagreed with the frame counter
// ============================================================================
module difference_unit #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DATA_W-1:0]   in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   out_data,
    output logic                  out_last,
    output logic                  frame_err
);

    localparam int              CNT_W    = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    // FIRST: the next beat opens a frame, so the previous value counts as zero.
    // MID:   the next beat is differenced against the stored history word.
    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_MID   = 1'b1
    } state_e;

    state_e                 state_q,     state_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [2*DATA_W-1:0]    histData_q,  histData_d;
    logic                   outValid_q,  outValid_d;
    logic [2*DATA_W-1:0]    outData_q,   outData_d;
    logic                   outLast_q,   outLast_d;
    logic                   frameErr_q,  frameErr_d;

    logic                   inBeat;
    logic                   cntAtEnd;
    logic                   frameEnd;
    logic [2*DATA_W-1:0]    prevWord;
    logic [DATA_W-1:0]      diffReal;
    logic [DATA_W-1:0]      diffImag;

    // Handshake decode.
    // A beat presented while clr is high is discarded, so it never counts as
    // accepted. The frame ends either on an explicit in_last or when the
    // counter reaches the nominal frame length. Whichever comes first wins,
    // so the stream realigns after a framing error.
    always_comb begin
        inBeat   = in_valid && in_ready && !clr;
        cntAtEnd = (cnt_q == LAST_CNT);
        frameEnd = in_last || cntAtEnd;
    end

    // Per-component subtraction.
    // Each half is subtracted separately, so a borrow out of the imag half
    // can never leak into the real half. Both halves wrap naturally at
    // DATA_W bits.
    always_comb begin
        prevWord = (state_q == ST_MID) ? histData_q : '0;
        diffReal = in_data[2*DATA_W-1:DATA_W] - prevWord[2*DATA_W-1:DATA_W];
        diffImag = in_data[DATA_W-1:0]        - prevWord[DATA_W-1:0];
    end

    // State register for the frame-position FSM.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // A beat that ends a frame always returns to FIRST, including a beat that
    // both opens and closes a frame. Any other beat leaves the FSM in MID.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_FIRST;
        end else if (inBeat) begin
            case (state_q)
                ST_FIRST: state_d = frameEnd ? ST_FIRST : ST_MID;
                ST_MID:   state_d = frameEnd ? ST_FIRST : ST_MID;
                default:  state_d = ST_FIRST;
            endcase
        end
    end

    // Output and port-facing logic.
    // The block is a one-stage pipeline, so it can take a new word whenever
    // the output slot is empty or is being drained in this same cycle. That
    // keeps throughput at one word per cycle with no bubbles.
    always_comb begin
        in_ready  = !outValid_q || out_ready;
        out_valid = outValid_q;
        out_data  = outData_q;
        out_last  = outLast_q;
        frame_err = frameErr_q;
    end

    // Datapath next-state.
    // The output word is only overwritten on an accepted beat. This holds it
    // stable while downstream stalls. A simultaneous pop and push simply
    // replaces the word, because the old one has just been taken.
    // frame_err defaults low so that it only ever pulses for one cycle.
    always_comb begin
        cnt_d      = cnt_q;
        histData_d = histData_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outLast_d  = outLast_q;
        frameErr_d = 1'b0;

        if (clr) begin
            cnt_d      = '0;
            histData_d = '0;
            outValid_d = 1'b0;
            outData_d  = '0;
            outLast_d  = 1'b0;
        end else begin
            if (out_ready) begin
                outValid_d = 1'b0;
            end
            if (inBeat) begin
                outValid_d = 1'b1;
                outData_d  = {diffReal, diffImag};
                outLast_d  = frameEnd;
                histData_d = in_data;
                cnt_d      = frameEnd ? '0 : cnt_q + CNT_W'(1);
                frameErr_d = (in_last != cntAtEnd);
            end
        end
    end

    // Datapath registers.
    // An asynchronous reset drops everything immediately, including any
    // partially processed frame.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q      <= '0;
            histData_q <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outLast_q  <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            histData_q <= histData_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outLast_q  <= outLast_d;
            frameErr_q <= frameErr_d;
        end
    end

endmodule
